// File: rtl/alu_issue_stage.sv
// Operand fetch/writeback around the combinational alu: 8x32 regfile, D -> X -> R; accept-to-result latency 2 cycles.
// Backpressure: a full R stage with res_ready low freezes X, and instr_ready drops combinationally from res_ready.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [2:0]       alu_op_select,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_rd,
    output logic [WIDTH-1:0] res_data
);
    localparam logic [2:0] OP_LDI = 3'd7;

    logic             x_valid;
    logic [2:0]       x_op;
    logic [2:0]       x_rd;
    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] x_b;
    logic [WIDTH-1:0] regs [NREGS];

    logic             adv_x;
    logic             accept;
    logic [2:0]       d_op;
    logic [2:0]       d_rd;
    logic [2:0]       d_rs1;
    logic [2:0]       d_rs2;
    logic [2:0]       d_xop;
    logic [WIDTH-1:0] d_rs1_val;
    logic [WIDTH-1:0] d_rs2_val;
    logic [WIDTH-1:0] d_a;
    logic [WIDTH-1:0] d_b;

    assign adv_x       = x_valid & (!res_valid | res_ready);
    assign instr_ready = !x_valid | adv_x;
    assign accept      = instr_valid & instr_ready;

    assign d_op  = instr[15:13];
    assign d_rd  = instr[12:10];
    assign d_rs1 = instr[9:7];
    assign d_rs2 = instr[6:4];

    // The regfile write for X lands on the same edge D samples, so forward it.
    assign d_rs1_val = (adv_x && x_rd == d_rs1) ? alu_result : regs[d_rs1];
    assign d_rs2_val = (adv_x && x_rd == d_rs2) ? alu_result : regs[d_rs2];

    always_comb begin
        d_xop = d_op;
        d_a   = d_rs1_val;
        d_b   = d_rs2_val;
        if (d_op == OP_LDI) begin
            d_xop = 3'd0;
            d_a   = {{(WIDTH-10){1'b0}}, instr[9:0]};
            d_b   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid <= 1'b0;
            x_op    <= '0;
            x_rd    <= '0;
            x_a     <= '0;
            x_b     <= '0;
        end else if (accept) begin
            x_valid <= 1'b1;
            x_op    <= d_xop;
            x_rd    <= d_rd;
            x_a     <= d_a;
            x_b     <= d_b;
        end else if (adv_x) begin
            x_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
        end else if (adv_x) begin
            res_valid <= 1'b1;
            res_rd    <= x_rd;
            res_data  <= alu_result;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (adv_x) begin
            regs[x_rd] <= alu_result;
        end
    end

    assign alu_op_select = x_op;
    assign alu_in0       = x_a;
    assign alu_in1       = x_b;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU closing the loop; results checked through an in-order scoreboard.
module tb_alu_issue_stage;
    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_op_select;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [31:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_rd;
    logic [31:0] res_data;

    alu_issue_stage #(.WIDTH(32), .NREGS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_op_select (alu_op_select),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_result    (alu_result),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_rd        (res_rd),
        .res_data      (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op_select)
            3'd0: alu_result = alu_in0 | alu_in1;
            3'd1: alu_result = alu_in0 & alu_in1;
            3'd2: alu_result = alu_in0 ^ alu_in1;
            3'd3: alu_result = alu_in0 + alu_in1;
            3'd4: alu_result = alu_in0 - alu_in1;
            3'd5: alu_result = alu_in0 * alu_in1;
            3'd6: alu_result = {31'b0, alu_in0 != alu_in1};
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic [31:0] data;
        int          acc;
    } sb_t;

    vec_t tbl [0:39];
    vec_t pend [$];
    sb_t  sb [$];
    int   n_assert;
    int   n_fail;
    int   cyc;
    bit   chk_lat;
    int   nsteps;

    function automatic logic [15:0] rop(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'd7, rd, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, {31'b0, instr_ready}, 32'd1);
        check({tag, "_op_select"}, {29'b0, alu_op_select}, 32'd0);
        check({tag, "_in0"}, alu_in0, 32'd0);
        check({tag, "_in1"}, alu_in1, 32'd0);
        check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
        check({tag, "_res_rd"}, {29'b0, res_rd}, 32'd0);
        check({tag, "_res_data"}, res_data, 32'd0);
    endtask

    // One clock: drive at the falling edge, resolve both handshakes, return just after the rising edge.
    task automatic step(input logic rr);
        vec_t v;
        sb_t  e;
        @(negedge clk);
        res_ready = rr;
        if (pend.size() > 0) begin
            instr_valid = 1'b1;
            instr       = pend[0].instr;
        end else begin
            instr_valid = 1'b0;
        end
        #1;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL spurious_result: got rd=%0d data=0x%08h, required no result", res_rd, res_data);
            end else begin
                e = sb.pop_front();
                check("res_rd", {29'b0, res_rd}, {29'b0, e.rd});
                check("res_data", res_data, e.data);
                if (chk_lat) check("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
        if (instr_valid && instr_ready) begin
            v = pend.pop_front();
            sb.push_back('{rd: v.instr[12:10], data: v.data, acc: cyc});
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic drain(input bit rand_rr, output int steps);
        steps = 0;
        while ((pend.size() > 0 || sb.size() > 0) && steps < 400) begin
            step(rand_rr ? 1'($urandom_range(0, 1)) : 1'b1);
            steps++;
        end
        check("drain_outstanding", 32'(pend.size() + sb.size()), 32'd0);
    endtask

    task automatic load(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pend.push_back(tbl[i]);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        chk_lat  = 1'b0;

        tbl[0]  = '{ldi(1, 10'd5), 32'd5};
        tbl[1]  = '{ldi(2, 10'd7), 32'd7};
        tbl[2]  = '{rop(3, 3, 1, 2), 32'd12};
        tbl[3]  = '{ldi(7, 10'h100), 32'h100};
        tbl[4]  = '{ldi(1, 10'hF0), 32'hF0};
        tbl[5]  = '{rop(5, 6, 1, 7), 32'h0000F000};
        tbl[6]  = '{rop(0, 1, 1, 6), 32'h0000F0F0};
        tbl[7]  = '{rop(5, 6, 1, 7), 32'h00F0F000};
        tbl[8]  = '{rop(5, 6, 6, 7), 32'hF0F00000};
        tbl[9]  = '{rop(0, 1, 1, 6), 32'hF0F0F0F0};
        tbl[10] = '{ldi(2, 10'hFF), 32'hFF};
        tbl[11] = '{ldi(5, 10'h10), 32'h10};
        tbl[12] = '{rop(5, 2, 2, 5), 32'h00000FF0};
        tbl[13] = '{rop(5, 6, 2, 7), 32'h000FF000};
        tbl[14] = '{rop(5, 6, 6, 7), 32'h0FF00000};
        tbl[15] = '{rop(0, 2, 2, 6), 32'h0FF00FF0};
        tbl[16] = '{rop(0, 4, 1, 2), 32'hFFF0FFF0};
        tbl[17] = '{rop(1, 4, 1, 2), 32'h00F000F0};
        tbl[18] = '{rop(2, 4, 1, 2), 32'hFF00FF00};
        tbl[19] = '{rop(4, 4, 2, 1), 32'h1EFF1F00};
        tbl[20] = '{rop(3, 4, 1, 2), 32'h00E100E0};
        tbl[21] = '{ldi(5, 10'd1000), 32'd1000};
        tbl[22] = '{rop(3, 6, 5, 5), 32'd2000};
        tbl[23] = '{rop(3, 5, 6, 5), 32'd3000};
        tbl[24] = '{rop(5, 4, 5, 6), 32'd6000000};
        tbl[25] = '{rop(6, 4, 1, 1), 32'd0};
        tbl[26] = '{rop(6, 4, 1, 2), 32'd1};
        tbl[27] = '{ldi(5, 10'h3FF), 32'h3FF};
        tbl[28] = '{rop(4, 5, 5, 5), 32'd0};
        tbl[29] = '{rop(3, 6, 5, 5), 32'd0};
        tbl[30] = '{ldi(1, 10'd1), 32'd1};
        tbl[31] = '{rop(3, 1, 1, 1), 32'd2};
        tbl[32] = '{rop(3, 1, 1, 1), 32'd4};
        tbl[33] = '{rop(3, 1, 1, 1), 32'd8};
        tbl[34] = '{rop(3, 1, 1, 1), 32'd16};
        tbl[35] = '{rop(0, 7, 1, 1), 32'd16};
        tbl[36] = '{ldi(1, 10'h11), 32'h11};
        tbl[37] = '{ldi(2, 10'h22), 32'h22};
        tbl[38] = '{ldi(3, 10'h33), 32'h33};
        tbl[39] = '{ldi(0, 10'h0), 32'h0};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b0;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill X and R, then reset asynchronously mid-cycle.
        load(0, 1);
        step(1'b0);
        step(1'b0);
        #3;
        check("prefill_res_valid", {31'b0, res_valid}, 32'd1);
        check("prefill_res_data", res_data, 32'd5);
        check("prefill_in0", alu_in0, 32'd7);
        check("prefill_instr_ready", {31'b0, instr_ready}, 32'd0);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        pend.delete();
        sb.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("heldrst");
        @(negedge clk);
        rst_n = 1'b1;
        pend.push_back('{rop(3, 3, 1, 2), 32'd0});
        drain(1'b0, nsteps);

        // Back-to-back LDI/LDI/ADD at full throughput.
        chk_lat = 1'b1;
        load(0, 2);
        drain(1'b0, nsteps);
        check("ldi_add_cycles", 32'(nsteps), 32'd5);

        load(3, 29);
        drain(1'b0, nsteps);
        chk_lat = 1'b0;

        // Three instructions offered while res_ready is held low.
        load(36, 38);
        step(1'b0);
        step(1'b0);
        #1;
        check("bp_instr_ready", {31'b0, instr_ready}, 32'd0);
        check("bp_in0", alu_in0, 32'h22);
        check("bp_op_select", {29'b0, alu_op_select}, 32'd0);
        check("bp_res_data", res_data, 32'h11);
        step(1'b0);
        #1;
        check("bp_in0_stable", alu_in0, 32'h22);
        check("bp_res_rd_stable", {29'b0, res_rd}, 32'd1);
        check("bp_instr_ready_held", {31'b0, instr_ready}, 32'd0);
        drain(1'b0, nsteps);
        repeat (3) step(1'b1);

        // Dependency chain under random backpressure.
        load(30, 35);
        drain(1'b1, nsteps);
        repeat (3) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
